// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one 16-bit word per fetch_start and writes it to the IR.
// Define FETCH_TIMEOUT_EN to abort fetches whose mem_ready does not arrive within TIMEOUT_CYC cycles.
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       PC_STEP     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              fetch_start,
    output logic              fetch_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       output_IR_Instru,
    output logic              output_IR_write,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_old,
    output logic              fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WRITE
    } state_t;

    state_t            state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // The address is held stable for the whole request because PC only moves in IDLE or WRITE.
    assign mem_addr = PC;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            PC               <= RESET_PC;
            PC_old           <= RESET_PC;
            output_IR_Instru <= 16'h0000;
            output_IR_write  <= 1'b0;
            fetch_done       <= 1'b0;
            mem_req          <= 1'b0;
            pend_valid       <= 1'b0;
            pend_pc          <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt         <= '0;
            fetch_error      <= 1'b0;
`endif
        end else begin
            output_IR_write <= 1'b0;
            fetch_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pc_load) PC <= pc_load_value;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (fetch_start) begin
                        state   <= S_REQ;
                        mem_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    // A branch resolved mid-fetch is parked until the current word is delivered.
                    if (pc_load) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= pc_load_value;
                    end
                    if (mem_ready) begin
                        output_IR_Instru <= mem_rdata;
                        output_IR_write  <= 1'b1;
                        fetch_done       <= 1'b1;
                        mem_req          <= 1'b0;
                        state            <= S_WRITE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        mem_req     <= 1'b0;
                        fetch_error <= 1'b1;
                        fetch_done  <= 1'b1;
                        pend_valid  <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_WRITE: begin
                    PC_old     <= PC;
                    pend_valid <= 1'b0;
                    if (pc_load)         PC <= pc_load_value;
                    else if (pend_valid) PC <= pend_pc;
                    else                 PC <= PC + ADDR_W'(PC_STEP);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef FETCH_TIMEOUT_EN
    // Never true; the timeout limit has no role without the wait counter.
    assign fetch_error = (TIMEOUT_CYC > 32'hFFFF_FFFE) && 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of fetch transactions plus reset/timeout sequences.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        fetch_done;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] output_IR_Instru;
    logic        output_IR_write;
    logic [15:0] PC;
    logic [15:0] PC_old;
    logic        fetch_error;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] prev_ir = 16'h0000;

    instruction_fetch_unit #(
        .ADDR_W(16), .PC_STEP(2), .RESET_PC(16'h0000), .TIMEOUT_CYC(4)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .fetch_start(fetch_start), .fetch_done(fetch_done),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .output_IR_Instru(output_IR_Instru), .output_IR_write(output_IR_write),
        .PC(PC), .PC_old(PC_old), .fetch_error(fetch_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        idle_load;   // pc_load together with fetch_start
        logic [15:0] idle_val;
        logic        req_load;    // pc_load in first REQ cycle
        logic [15:0] req_val;
        logic        req_load2;   // pc_load in last REQ cycle
        logic [15:0] req_val2;
        logic        write_load;  // pc_load in WRITE
        logic [15:0] write_val;
        int          waits;
        logic [15:0] rdata;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
        logic [15:0] exp_pc_old;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_fetch(input vec_t v, input int idx);
        fetch_start   = 1'b1;
        pc_load       = v.idle_load;
        pc_load_value = v.idle_val;
        @(posedge CLK); #1;
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            if (w == 0 && v.req_load) begin
                pc_load = 1'b1; pc_load_value = v.req_val;
            end
            if (w == v.waits && v.req_load2) begin
                pc_load = 1'b1; pc_load_value = v.req_val2;
            end
            mem_ready = (w == v.waits);
            mem_rdata = (w == v.waits) ? v.rdata : 16'hDEAD;
            check($sformatf("v%0d w%0d mem_req", idx, w), 32'(mem_req), 32'd1);
            check($sformatf("v%0d w%0d mem_addr", idx, w), 32'(mem_addr), 32'(v.exp_addr));
            check($sformatf("v%0d w%0d ir_hold", idx, w), 32'(output_IR_Instru), 32'(prev_ir));
            check($sformatf("v%0d w%0d ir_write_low", idx, w), 32'(output_IR_write), 32'd0);
            @(posedge CLK); #1;
            pc_load   = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 16'h0000;
        end
        // WRITE cycle: 2 + waits cycles after fetch_start
        check($sformatf("v%0d ir_write", idx), 32'(output_IR_write), 32'd1);
        check($sformatf("v%0d fetch_done", idx), 32'(fetch_done), 32'd1);
        check($sformatf("v%0d ir_data", idx), 32'(output_IR_Instru), 32'(v.rdata));
        check($sformatf("v%0d req_dropped", idx), 32'(mem_req), 32'd0);
        if (v.write_load) begin
            pc_load = 1'b1; pc_load_value = v.write_val;
        end
        @(posedge CLK); #1;
        pc_load = 1'b0;
        check($sformatf("v%0d write_pulse_end", idx), 32'(output_IR_write), 32'd0);
        check($sformatf("v%0d done_pulse_end", idx), 32'(fetch_done), 32'd0);
        check($sformatf("v%0d pc", idx), 32'(PC), 32'(v.exp_pc));
        check($sformatf("v%0d pc_old", idx), 32'(PC_old), 32'(v.exp_pc_old));
        prev_ir = v.rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            il  ival      rl  rval      rl2 rval2     wl  wval      w  rdata     addr      pc        pc_old
        vecs[0] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 16'h1A2B, 16'h0000, 16'h0002, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 3, 16'h3C4D, 16'h0002, 16'h0004, 16'h0002};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 16'h5E6F, 16'h0004, 16'h0040, 16'h0004};
        vecs[3] = '{1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 16'h7788, 16'hFFFE, 16'h0000, 16'hFFFE};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 16'h0200, 2, 16'h99AA, 16'h0000, 16'h0200, 16'h0000};
        vecs[5] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 16'hBBCC, 16'h1234, 16'h1236, 16'h1234};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 16'h0300, 1'b1, 16'h0400, 1'b0, 16'h0000, 2, 16'hDDEE, 16'h1236, 16'h0400, 16'h1236};

        // Reset state
        #12;
        check("rst pc", 32'(PC), 32'h0000);
        check("rst pc_old", 32'(PC_old), 32'h0000);
        check("rst ir", 32'(output_IR_Instru), 32'h0000);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'h0000);
        check("rst outputs", 32'({output_IR_write, fetch_done, fetch_error}), 32'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 7; i++) run_fetch(vecs[i], i);

        // pc_load in IDLE without a fetch
        pc_load = 1'b1; pc_load_value = 16'h0800;
        @(posedge CLK); #1;
        pc_load = 1'b0;
        check("idle_load pc", 32'(PC), 32'h0800);
        check("idle_load no_req", 32'(mem_req), 32'd0);

        // fetch_start during REQ is not queued
        fetch_start = 1'b1;
        @(posedge CLK); #1;
        fetch_start = 1'b1;
        @(posedge CLK); #1;
        fetch_start = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h4242;
        check("extra_start addr", 32'(mem_addr), 32'h0800);
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        check("extra_start write", 32'(output_IR_write), 32'd1);
        @(posedge CLK); #1;
        check("extra_start pc", 32'(PC), 32'h0802);
        @(posedge CLK); #1;
        check("extra_start no_requeue", 32'(mem_req), 32'd0);
        prev_ir = 16'h4242;

`ifndef FETCH_TIMEOUT_EN
        // Without the timeout the request waits indefinitely
        fetch_start = 1'b1;
        @(posedge CLK); #1;
        fetch_start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("long_wait mem_req", 32'(mem_req), 32'd1);
        check("long_wait no_error", 32'(fetch_error), 32'd0);
        check("long_wait ir_hold", 32'(output_IR_Instru), 32'(prev_ir));
`else
        fetch_start = 1'b1;
        @(posedge CLK); #1;
        fetch_start = 1'b0;
        @(posedge CLK); #1;
`endif

        // Reset mid-REQ drops mem_req asynchronously
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst mem_req", 32'(mem_req), 32'd0);
        check("mid_rst pc", 32'(PC), 32'h0000);
        check("mid_rst pc_old", 32'(PC_old), 32'h0000);
        check("mid_rst ir", 32'(output_IR_Instru), 32'h0000);
        mem_ready = 1'b1; mem_rdata = 16'hFFFF;
        @(posedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        check("late_ready ignored ir", 32'(output_IR_Instru), 32'h0000);
        check("late_ready no_write", 32'({output_IR_write, fetch_done, mem_req}), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // mem_ready never arrives: abort after TIMEOUT_CYC=4 request cycles
        fetch_start = 1'b1;
        @(posedge CLK); #1;
        fetch_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to req c%0d", i), 32'(mem_req), 32'd1);
            @(posedge CLK); #1;
        end
        check("to mem_req_dropped", 32'(mem_req), 32'd0);
        check("to fetch_done", 32'(fetch_done), 32'd1);
        check("to no_write", 32'(output_IR_write), 32'd0);
        check("to fetch_error", 32'(fetch_error), 32'd1);
        check("to pc", 32'(PC), 32'h0000);
        @(posedge CLK); #1;
        check("to done_end", 32'(fetch_done), 32'd0);
        check("to error_sticky", 32'(fetch_error), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Writer side of the instruction register (IR) interface.
- Owns the program counter (PC) and fetches one 16-bit instruction per request from instruction memory through a ready-handshake.
- Drives the instruction word plus a one-cycle write strobe into the IR.
- Sits between the multi-cycle control FSM (start/done handshake) and memory; supports PC reload for branches and jumps.

Parameters:
- ADDR_W, 16, PC and memory address width.
- PC_STEP, 2, PC increment per completed fetch (byte-addressed 16-bit words).
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT_CYC, 64, max wait cycles for mem_ready (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- fetch_start  input  1  control FSM requests one fetch; sampled only in IDLE.
- fetch_done  output  1  one-cycle pulse when the instruction has been handed to the IR.
- pc_load  input  1  load PC with pc_load_value.
- pc_load_value  input  ADDR_W  branch/jump target.
- mem_req  output  1  read request, held until mem_ready.
- mem_addr  output  ADDR_W  read address, equal to PC while mem_req=1.
- mem_rdata  input  16  instruction data, valid when mem_ready=1.
- mem_ready  input  1  memory returns data this cycle.
- output_IR_Instru  output  16  instruction word for the IR; holds its last value.
- output_IR_write  output  1  IR write enable, one-cycle pulse.
- PC  output  ADDR_W  current PC.
- PC_old  output  ADDR_W  address of the most recently fetched instruction.
- fetch_error  output  1  sticky timeout flag; always 0 when the optional feature is absent.

Behaviour:
- Reset (async, Reset_n=0):
  - PC=RESET_PC, PC_old=RESET_PC.
  - output_IR_Instru=16'h0000.
  - mem_req, output_IR_write, fetch_done and fetch_error all 0.
  - mem_addr=PC; state=IDLE; pending-load register cleared.
  - Reset mid-fetch drops mem_req immediately; any late mem_ready is ignored.
- FSM states:
  - IDLE:
    - fetch_start=1 -> REQ next cycle.
    - pc_load=1 loads PC at the clock edge.
    - If fetch_start and pc_load are both asserted, the load applies first and the fetch uses the new PC.
  - REQ:
    - mem_req=1, mem_addr=PC.
    - On mem_ready=1: capture mem_rdata into output_IR_Instru and go to WRITE.
    - Zero-wait memory (mem_ready in the first REQ cycle) is legal.
  - WRITE:
    - output_IR_write=1 and fetch_done=1 for exactly one cycle.
    - PC_old<=PC.
    - PC<=PC+PC_STEP, or the pending or current load target if one exists.
    - Next state is IDLE.
- Latency: fetch_start to output_IR_write = 2 + N cycles, where N is the number of memory wait cycles (N=0 gives 2).
- Handshake rules:
  - fetch_start outside IDLE is ignored; there is no queueing.
  - mem_req never deasserts before mem_ready except on reset or timeout.
- pc_load during REQ:
  - The target is latched as pending and the memory access is not aborted.
  - In WRITE the pending value replaces the increment; PC_old still receives the fetched address.
  - A second load in REQ overwrites the pending value; a load in WRITE wins over the pending value.
- Arithmetic: PC increment is modulo 2^ADDR_W. 16'hFFFE+2 -> 16'h0000 with no flag.
- output_IR_Instru changes only on mem_ready capture in REQ and is stable at all other times.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter runs in REQ.
  - If mem_ready is still absent after TIMEOUT_CYC cycles: drop mem_req, set fetch_error=1 (sticky until reset), pulse fetch_done without output_IR_write, leave PC unchanged, return to IDLE.
- Undefined: no counter; REQ waits indefinitely; fetch_error is tied to 0.

Test Plan:
- Reset then fetch_start with memory returning 16'h1A2B at 0x0000 and 0 waits -> output_IR_write pulses at cycle 2, output_IR_Instru=16'h1A2B, PC=0x0002, PC_old=0x0000, fetch_done pulses once.
- mem_ready delayed 3 cycles -> mem_req held 4 cycles with mem_addr=0x0002; write at cycle 5; output_IR_Instru unchanged during the wait.
- pc_load=1 with value 0x0040 during REQ -> the fetch completes from the old address, then PC=0x0040 instead of old+2.
- PC loaded to 0xFFFE, then fetch -> PC wraps to 0x0000, PC_old=0xFFFE.
- fetch_start pulsed during REQ, then Reset_n asserted mid-REQ -> the extra start is ignored; reset clears mem_req asynchronously and all outputs return to reset values.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYC=4, mem_ready never asserted -> after 4 cycles fetch_error=1, fetch_done pulses, output_IR_write stays 0, PC unchanged.
